// File: rtl/segrw_pkg.sv
// Shared definitions for the segrw read-modify-write initiator: state encoding,
// default widths and the read/write encoding carried on the write stream.
package segrw_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ISSUE  = 3'd1,
        RD_WAIT   = 3'd2,
        WR_ISSUE  = 3'd3,
        RESULT    = 3'd4,
        EOS_ISSUE = 3'd5
    } state_t;

endpackage

// File: rtl/segrw_rmw_init_if.sv
// Stream bundle between the RMW initiator (master) and its request source,
// segment operator and result sink (slave side).
interface segrw_rmw_init_if
    import segrw_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] req_addr_d;
    logic [DATA_W-1:0] req_inc_d;
    logic              req_e;
    logic              req_v;
    logic              req_b;

    logic [ADDR_W-1:0] addr_d;
    logic              addr_e;
    logic              addr_v;
    logic              addr_b;

    logic              write_d;
    logic              write_e;
    logic              write_v;
    logic              write_b;

    logic [DATA_W-1:0] dataW_d;
    logic              dataW_e;
    logic              dataW_v;
    logic              dataW_b;

    logic [DATA_W-1:0] dataR_d;
    logic              dataR_e;
    logic              dataR_v;
    logic              dataR_b;

    logic [DATA_W-1:0] res_d;
    logic              res_e;
    logic              res_v;
    logic              res_b;

    logic              err;

    modport master (
        input  req_addr_d, req_inc_d, req_e, req_v,
        output req_b,
        output addr_d, addr_e, addr_v,
        input  addr_b,
        output write_d, write_e, write_v,
        input  write_b,
        output dataW_d, dataW_e, dataW_v,
        input  dataW_b,
        input  dataR_d, dataR_e, dataR_v,
        output dataR_b,
        output res_d, res_e, res_v,
        input  res_b,
        output err
    );

    modport slave (
        output req_addr_d, req_inc_d, req_e, req_v,
        input  req_b,
        input  addr_d, addr_e, addr_v,
        output addr_b,
        input  write_d, write_e, write_v,
        output write_b,
        input  dataW_d, dataW_e, dataW_v,
        output dataW_b,
        output dataR_d, dataR_e, dataR_v,
        input  dataR_b,
        input  res_d, res_e, res_v,
        output res_b,
        input  err
    );

endinterface

// File: rtl/segrw_rmw_init_dp.sv
// Datapath of the RMW initiator: request address/increment registers and the
// write-back value register. SEGRW_RMW_SATURATE_EN selects a saturating add.
module segrw_rmw_init_dp
    import segrw_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req_s,
    input  logic [ADDR_W-1:0] req_addr_d,
    input  logic [DATA_W-1:0] req_inc_d,
    input  logic              load_rd_s,
    input  logic [DATA_W-1:0] rd_data_d,
    output logic [ADDR_W-1:0] addr_r,
    output logic [DATA_W-1:0] wdata_r
);

    logic [DATA_W-1:0] inc_r;

    function automatic logic [DATA_W-1:0] rmw_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef SEGRW_RMW_SATURATE_EN
        if (sum[DATA_W]) begin
            rmw_add = {DATA_W{1'b1}};
        end else begin
            rmw_add = sum[DATA_W-1:0];
        end
`else
        rmw_add = sum[DATA_W-1:0];
`endif
    endfunction

    // Request capture; the sum is formed as read data arrives so WR_ISSUE drives a stable register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r  <= {ADDR_W{1'b0}};
            inc_r   <= {DATA_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else begin
            if (load_req_s) begin
                addr_r <= req_addr_d;
                inc_r  <= req_inc_d;
            end
            if (load_rd_s) begin
                wdata_r <= rmw_add(rd_data_d, inc_r);
            end
        end
    end

endmodule

// File: rtl/segrw_rmw_init.sv
// segrw_rmw_init: one read-modify-write per request token on the segrw streams.
// Build option: define SEGRW_RMW_SATURATE_EN for a saturating add (default wraps).
module segrw_rmw_init
    import segrw_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    segrw_rmw_init_if.master bus
);

    state_t            state_r;
    state_t            state_s;
    logic              addr_tk_r;
    logic              write_tk_r;
    logic              dataw_tk_r;
    logic              res_tk_r;
    logic              req_b_r;
    logic              datar_b_r;
    logic              err_r;
    logic              load_req_s;
    logic              load_rd_s;
    logic              err_set_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              addr_v_s;
    logic              addr_e_s;
    logic [ADDR_W-1:0] addr_d_s;
    logic              write_v_s;
    logic              write_e_s;
    logic              write_d_s;
    logic              dataw_v_s;
    logic              dataw_e_s;
    logic [DATA_W-1:0] dataw_d_s;
    logic              res_v_s;
    logic              res_e_s;
    logic [DATA_W-1:0] res_d_s;

    logic              req_fire_s;
    logic              addr_fire_s;
    logic              write_fire_s;
    logic              dataw_fire_s;
    logic              res_fire_s;
    logic              datar_fire_s;
    logic              addr_done_s;
    logic              write_done_s;
    logic              dataw_done_s;
    logic              res_done_s;

    segrw_rmw_init_dp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dp (
        .clock      (clock),
        .reset      (reset),
        .load_req_s (load_req_s),
        .req_addr_d (bus.req_addr_d),
        .req_inc_d  (bus.req_inc_d),
        .load_rd_s  (load_rd_s),
        .rd_data_d  (bus.dataR_d),
        .addr_r     (addr_r),
        .wdata_r    (wdata_r)
    );

    assign req_fire_s   = bus.req_v & ~req_b_r;
    assign addr_fire_s  = addr_v_s & ~bus.addr_b;
    assign write_fire_s = write_v_s & ~bus.write_b;
    assign dataw_fire_s = dataw_v_s & ~bus.dataW_b;
    assign res_fire_s   = res_v_s & ~bus.res_b;
    assign datar_fire_s = bus.dataR_v & ~datar_b_r;
    assign addr_done_s  = addr_tk_r | addr_fire_s;
    assign write_done_s = write_tk_r | write_fire_s;
    assign dataw_done_s = dataw_tk_r | dataw_fire_s;
    assign res_done_s   = res_tk_r | res_fire_s;

    // Stream outputs decoded from state and taken flags only; back-pressure never reaches a _v.
    always_comb begin
        addr_v_s  = 1'b0;
        addr_e_s  = 1'b0;
        addr_d_s  = {ADDR_W{1'b0}};
        write_v_s = 1'b0;
        write_e_s = 1'b0;
        write_d_s = RD;
        dataw_v_s = 1'b0;
        dataw_e_s = 1'b0;
        dataw_d_s = {DATA_W{1'b0}};
        res_v_s   = 1'b0;
        res_e_s   = 1'b0;
        res_d_s   = {DATA_W{1'b0}};
        case (state_r)
            RD_ISSUE: begin
                addr_v_s  = ~addr_tk_r;
                addr_d_s  = addr_r;
                write_v_s = ~write_tk_r;
                write_d_s = RD;
            end
            WR_ISSUE: begin
                addr_v_s  = ~addr_tk_r;
                addr_d_s  = addr_r;
                write_v_s = ~write_tk_r;
                write_d_s = WR;
                dataw_v_s = ~dataw_tk_r;
                dataw_d_s = wdata_r;
            end
            RESULT: begin
                res_v_s = 1'b1;
                res_d_s = wdata_r;
            end
            EOS_ISSUE: begin
                addr_v_s  = ~addr_tk_r;
                addr_e_s  = ~addr_tk_r;
                write_v_s = ~write_tk_r;
                write_e_s = ~write_tk_r;
                dataw_v_s = ~dataw_tk_r;
                dataw_e_s = ~dataw_tk_r;
                res_v_s   = ~res_tk_r;
                res_e_s   = ~res_tk_r;
            end
            default: begin
                addr_v_s = 1'b0;
            end
        endcase
    end

    // Next-state logic plus datapath load strobes.
    always_comb begin
        state_s    = state_r;
        load_req_s = 1'b0;
        load_rd_s  = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_fire_s && bus.req_e) begin
                    state_s = EOS_ISSUE;
                end else if (req_fire_s) begin
                    state_s    = RD_ISSUE;
                    load_req_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ISSUE: begin
                if (addr_done_s && write_done_s) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_ISSUE;
                end
            end
            RD_WAIT: begin
                // An EOS on the read-data stream means the segment refused the read.
                if (datar_fire_s && bus.dataR_e) begin
                    state_s   = IDLE;
                    err_set_s = 1'b1;
                end else if (datar_fire_s) begin
                    state_s   = WR_ISSUE;
                    load_rd_s = 1'b1;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_ISSUE: begin
                if (addr_done_s && write_done_s && dataw_done_s) begin
                    state_s = RESULT;
                end else begin
                    state_s = WR_ISSUE;
                end
            end
            RESULT: begin
                if (res_fire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESULT;
                end
            end
            EOS_ISSUE: begin
                if (addr_done_s && write_done_s && dataw_done_s && res_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = EOS_ISSUE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, per-stream taken flags, registered back-pressure and sticky error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            addr_tk_r  <= 1'b0;
            write_tk_r <= 1'b0;
            dataw_tk_r <= 1'b0;
            res_tk_r   <= 1'b0;
            req_b_r    <= 1'b1;
            datar_b_r  <= 1'b1;
            err_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            req_b_r   <= (state_s != IDLE);
            datar_b_r <= (state_s != RD_WAIT);
            err_r     <= err_r | err_set_s;
            if (state_s != state_r) begin
                addr_tk_r  <= 1'b0;
                write_tk_r <= 1'b0;
                dataw_tk_r <= 1'b0;
                res_tk_r   <= 1'b0;
            end else begin
                addr_tk_r  <= addr_tk_r | addr_fire_s;
                write_tk_r <= write_tk_r | write_fire_s;
                dataw_tk_r <= dataw_tk_r | dataw_fire_s;
                res_tk_r   <= res_tk_r | res_fire_s;
            end
        end
    end

    assign bus.req_b   = req_b_r;
    assign bus.addr_d  = addr_d_s;
    assign bus.addr_e  = addr_e_s;
    assign bus.addr_v  = addr_v_s;
    assign bus.write_d = write_d_s;
    assign bus.write_e = write_e_s;
    assign bus.write_v = write_v_s;
    assign bus.dataW_d = dataw_d_s;
    assign bus.dataW_e = dataw_e_s;
    assign bus.dataW_v = dataw_v_s;
    assign bus.dataR_b = datar_b_r;
    assign bus.res_d   = res_d_s;
    assign bus.res_e   = res_e_s;
    assign bus.res_v   = res_v_s;
    assign bus.err     = err_r;

endmodule

// File: tb/tb_segrw_rmw_init.sv
// Directed bench for segrw_rmw_init: table of RMW vectors plus hand-written
// back-pressure, EOS, read-error and mid-operation reset sequences.
module tb_segrw_rmw_init;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    segrw_rmw_init_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    segrw_rmw_init #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] init;
        logic [DW-1:0] inc;
        logic [DW-1:0] exp_wrap;
        logic [DW-1:0] exp_sat;
    } vec_t;

    vec_t vecs [7];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Segment model state
    logic [DW-1:0] mem [16];
    logic [AW-1:0] aq [$];
    logic          wq [$];
    logic [DW-1:0] dq [$];
    logic [DW-1:0] rq [$];
    bit            inject_e = 1'b0;
    int n_rd = 0, n_wr = 0, n_res = 0, n_dr_e = 0;
    int eos_a = 0, eos_w = 0, eos_d = 0, eos_r = 0;
    int n_addr_tok = 0, n_wr_tok = 0;
    int rd_edge = -1, wr_edge = -1, res_edge = -1;
    logic [DW-1:0] res_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: log transfers seen before the edge, pass the edge, update the segment model.
    task automatic tick();
        if (bus.addr_v && !bus.addr_b) begin
            n_addr_tok++;
            if (bus.addr_e) eos_a++;
            else aq.push_back(bus.addr_d);
        end
        if (bus.write_v && !bus.write_b) begin
            n_wr_tok++;
            if (bus.write_e) eos_w++;
            else begin
                wq.push_back(bus.write_d);
                if (bus.write_d == 1'b0) rd_edge = cyc;
            end
        end
        if (bus.dataW_v && !bus.dataW_b) begin
            if (bus.dataW_e) eos_d++;
            else begin
                dq.push_back(bus.dataW_d);
                wr_edge = cyc;
            end
        end
        if (bus.res_v && !bus.res_b) begin
            if (bus.res_e) eos_r++;
            else begin
                n_res++;
                res_val  = bus.res_d;
                res_edge = cyc;
            end
        end
        if (bus.dataR_v && !bus.dataR_b) begin
            void'(rq.pop_front());
            if (bus.dataR_e) begin
                n_dr_e++;
                inject_e = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        while (aq.size() > 0 && wq.size() > 0) begin
            if (wq[0] == 1'b0) begin
                rq.push_back(mem[aq[0]]);
                void'(aq.pop_front());
                void'(wq.pop_front());
                n_rd++;
            end else if (dq.size() > 0) begin
                mem[aq[0]] = dq[0];
                void'(aq.pop_front());
                void'(wq.pop_front());
                void'(dq.pop_front());
                n_wr++;
            end else begin
                break;
            end
        end
        if (rq.size() > 0) begin
            bus.dataR_v = 1'b1;
            bus.dataR_e = inject_e;
            bus.dataR_d = inject_e ? 8'h00 : rq[0];
        end else begin
            bus.dataR_v = 1'b0;
            bus.dataR_e = 1'b0;
            bus.dataR_d = 8'h00;
        end
        @(negedge clock);
    endtask

    task automatic run_op(input string nm, input logic [AW-1:0] a,
                          input logic [DW-1:0] inc, input logic [DW-1:0] exp);
        int t0;
        int wr0;
        int res0;
        int k;
        check({nm, "_req_b_idle"}, bus.req_b, 1'b0);
        wr0  = n_wr;
        res0 = n_res;
        t0   = cyc;
        bus.req_v      = 1'b1;
        bus.req_e      = 1'b0;
        bus.req_addr_d = a;
        bus.req_inc_d  = inc;
        tick();
        bus.req_v      = 1'b0;
        bus.req_addr_d = 4'h0;
        bus.req_inc_d  = 8'h00;
        k = 0;
        while (n_res == res0 && k < 20) begin
            tick();
            k++;
        end
        check({nm, "_res_count"}, n_res - res0, 1);
        check({nm, "_res_d"}, res_val, exp);
        check({nm, "_rd_latency"}, rd_edge - t0, 1);
        check({nm, "_wr_latency"}, wr_edge - t0, 3);
        check({nm, "_res_latency"}, res_edge - t0, 4);
        check({nm, "_mem"}, mem[a], exp);
        check({nm, "_writes"}, n_wr - wr0, 1);
        check({nm, "_req_b_after"}, bus.req_b, 1'b0);
    endtask

    initial begin
        int a0, w0, wr0, res0, k;
        logic [DW-1:0] exp;

        vecs[0] = '{addr: 4'd3,  init: 8'h05, inc: 8'h02, exp_wrap: 8'h07, exp_sat: 8'h07};
        vecs[1] = '{addr: 4'd1,  init: 8'hF0, inc: 8'h20, exp_wrap: 8'h10, exp_sat: 8'hFF};
        vecs[2] = '{addr: 4'd15, init: 8'hFF, inc: 8'h01, exp_wrap: 8'h00, exp_sat: 8'hFF};
        vecs[3] = '{addr: 4'd0,  init: 8'h00, inc: 8'h00, exp_wrap: 8'h00, exp_sat: 8'h00};
        vecs[4] = '{addr: 4'd8,  init: 8'h7F, inc: 8'h80, exp_wrap: 8'hFF, exp_sat: 8'hFF};
        vecs[5] = '{addr: 4'd10, init: 8'hAA, inc: 8'h55, exp_wrap: 8'hFF, exp_sat: 8'hFF};
        vecs[6] = '{addr: 4'd6,  init: 8'h80, inc: 8'h80, exp_wrap: 8'h00, exp_sat: 8'hFF};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.req_addr_d = 4'h0;
        bus.req_inc_d  = 8'h00;
        bus.req_e      = 1'b0;
        bus.req_v      = 1'b0;
        bus.addr_b     = 1'b0;
        bus.write_b    = 1'b0;
        bus.dataW_b    = 1'b0;
        bus.res_b      = 1'b0;
        bus.dataR_d    = 8'h00;
        bus.dataR_e    = 1'b0;
        bus.dataR_v    = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_addr_v", bus.addr_v, 1'b0);
        check("rst_write_v", bus.write_v, 1'b0);
        check("rst_dataW_v", bus.dataW_v, 1'b0);
        check("rst_res_v", bus.res_v, 1'b0);
        check("rst_addr_d", bus.addr_d, 4'h0);
        check("rst_res_d", bus.res_d, 8'h00);
        check("rst_req_b", bus.req_b, 1'b1);
        check("rst_dataR_b", bus.dataR_b, 1'b1);
        check("rst_err", bus.err, 1'b0);
        reset = 1'b1;
        tick();
        check("rel_req_b", bus.req_b, 1'b0);

        // Table of RMW vectors, back-to-back, no back-pressure
        for (int i = 0; i < 7; i++) begin
            mem[vecs[i].addr] = vecs[i].init;
`ifdef SEGRW_RMW_SATURATE_EN
            exp = vecs[i].exp_sat;
`else
            exp = vecs[i].exp_wrap;
`endif
            run_op($sformatf("vec%0d", i), vecs[i].addr, vecs[i].inc, exp);
        end

        // Staggered back-pressure: addr stalled 3 cycles, write free
        mem[2]     = 8'h10;
        a0         = n_addr_tok;
        w0         = n_wr_tok;
        res0       = n_res;
        bus.req_v      = 1'b1;
        bus.req_addr_d = 4'd2;
        bus.req_inc_d  = 8'h03;
        tick();
        bus.req_v  = 1'b0;
        bus.addr_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_addr_v", bus.addr_v, 1'b1);
            check("stall_addr_d", bus.addr_d, 4'd2);
            if (i > 0) check("stall_write_v_dropped", bus.write_v, 1'b0);
            tick();
        end
        check("stall_dataR_b_before", bus.dataR_b, 1'b1);
        bus.addr_b = 1'b0;
        check("stall_addr_v_release", bus.addr_v, 1'b1);
        tick();
        check("stall_rd_wait", bus.dataR_b, 1'b0);
        check("stall_addr_tokens", n_addr_tok - a0, 1);
        check("stall_write_tokens", n_wr_tok - w0, 1);
        k = 0;
        while (n_res == res0 && k < 20) begin
            tick();
            k++;
        end
        check("stall_res_d", res_val, 8'h13);
        check("stall_mem", mem[2], 8'h13);

        // EOS request with a short dataW stall
        bus.req_v = 1'b1;
        bus.req_e = 1'b1;
        tick();
        bus.req_v = 1'b0;
        bus.req_e = 1'b0;
        k = 0;
        while (!(eos_a > 0 && eos_w > 0 && eos_d > 0 && eos_r > 0) && k < 12) begin
            bus.dataW_b = (k < 2) ? 1'b1 : 1'b0;
            tick();
            k++;
        end
        bus.dataW_b = 1'b0;
        tick();
        tick();
        check("eos_addr", eos_a, 1);
        check("eos_write", eos_w, 1);
        check("eos_dataW", eos_d, 1);
        check("eos_res", eos_r, 1);
        check("eos_idle_req_b", bus.req_b, 1'b0);
        mem[12] = 8'h40;
        run_op("post_eos", 4'd12, 8'h01, 8'h41);

        // dataR returns end-of-stream: error, no write, no result
        mem[4]   = 8'h33;
        inject_e = 1'b1;
        wr0      = n_wr;
        res0     = n_res;
        a0       = n_dr_e;
        bus.req_v      = 1'b1;
        bus.req_addr_d = 4'd4;
        bus.req_inc_d  = 8'h01;
        tick();
        bus.req_v = 1'b0;
        k = 0;
        while (n_dr_e == a0 && k < 10) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check("rderr_seen", n_dr_e - a0, 1);
        check("rderr_err", bus.err, 1'b1);
        check("rderr_no_write", n_wr - wr0, 0);
        check("rderr_no_res", n_res - res0, 0);
        check("rderr_mem", mem[4], 8'h33);
        check("rderr_idle", bus.req_b, 1'b0);
        run_op("after_err", 4'd4, 8'h01, 8'h34);
        check("err_sticky", bus.err, 1'b1);

        // Reset asserted while in WR_ISSUE
        mem[5] = 8'h20;
        wr0    = n_wr;
        res0   = n_res;
        bus.req_v      = 1'b1;
        bus.req_addr_d = 4'd5;
        bus.req_inc_d  = 8'h01;
        tick();
        bus.req_v = 1'b0;
        tick();
        tick();
        check("mid_in_wr_issue", bus.dataW_v, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_addr_v", bus.addr_v, 1'b0);
        check("mid_rst_write_v", bus.write_v, 1'b0);
        check("mid_rst_dataW_v", bus.dataW_v, 1'b0);
        check("mid_rst_res_v", bus.res_v, 1'b0);
        check("mid_rst_req_b", bus.req_b, 1'b1);
        @(negedge clock);
        tick();
        reset = 1'b1;
        repeat (8) tick();
        check("mid_no_write", n_wr - wr0, 0);
        check("mid_no_res", n_res - res0, 0);
        check("mid_mem", mem[5], 8'h20);
        check("mid_req_b", bus.req_b, 1'b0);
        check("mid_err_cleared", bus.err, 1'b0);
        run_op("after_rst", 4'd5, 8'h01, 8'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/segrw_rmw_init.md
Name: segrw_rmw_init

Overview:
- Initiator for the segment read/write stream interface.
- Drives the addr/write/dataW streams into a segrw segment operator and consumes its dataR stream.
- For each incoming request token (address, increment), performs one read-modify-write: read the word, add the increment, write it back, and emit the new value on a result stream.
- Sits between a compute operator and a segment memory operator in the stream fabric.

Parameters:
- ADDR_W, 4, width of addr_d and req_addr_d.
- DATA_W, 8, width of dataR_d, dataW_d, req_inc_d and res_d.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_addr_d  in  ADDR_W  request address.
- req_inc_d  in  DATA_W  request increment.
- req_e  in  1  end-of-stream marker on the request token.
- req_v  in  1  request token valid.
- req_b  out  1  request back-pressure.
- addr_d, addr_e, addr_v  out  ADDR_W/1/1  address stream to the segment.
- addr_b  in  1  address back-pressure.
- write_d, write_e, write_v  out  1/1/1  read(0)/write(1) stream.
- write_b  in  1  write back-pressure.
- dataW_d, dataW_e, dataW_v  out  DATA_W/1/1  write-data stream.
- dataW_b  in  1  write-data back-pressure.
- dataR_d, dataR_e, dataR_v  in  DATA_W/1/1  read-data stream from the segment.
- dataR_b  out  1  read-data back-pressure.
- res_d, res_e, res_v  out  DATA_W/1/1  result stream.
- res_b  in  1  result back-pressure.
- err  out  1  sticky protocol error flag.

Behaviour:
- Stream rule: a token transfers on a rising edge when _v=1 and _b=0. A token with _e=1 is end-of-stream; its _d is don't-care (driven 0).
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All output _v/_e/_d = 0, req_b=1, dataR_b=1, err=0.
  - On release, req_b=0 in IDLE.
- IDLE: req_b=0.
  - Data token: latch addr/inc, go to RD_ISSUE.
  - EOS token: go to EOS_ISSUE.
- RD_ISSUE: drive addr_v=1, write_v=1, write_d=0.
  - Each stream keeps a taken flag; its _v drops the cycle after its own transfer.
  - When both have transferred (same or different cycles), go to RD_WAIT.
- RD_WAIT: dataR_b=0 (1 in every other state).
  - dataR data token: capture, go to WR_ISSUE.
  - dataR_e=1: set err, go to IDLE with no write and no result.
- WR_ISSUE: drive addr, write_d=1, and dataW_d = (rdata + inc) mod 2^DATA_W, all with _v=1.
  - Per-stream taken flags as in RD_ISSUE.
  - When all three have transferred, go to RESULT.
- RESULT: res_v=1, res_d = written value. Hold until res_b=0, then go to IDLE.
- EOS_ISSUE: drive addr_e/write_e/dataW_e/res_e=1 with _v=1, per-stream taken flags. When all four have transferred, go to IDLE.
- Outputs are registered or decoded from state only; no combinational path from any _b input to any _v output.
- Latency: request accepted at cycle t with zero back-pressure and dataR valid at t+2 → res_v=1 at t+4. Throughput: one op per 5 cycles.
- Held outputs stay stable while stalled.
- req_b=1 in every state except IDLE.
- err clears only on reset.
- Reset mid-operation abandons the op; no partial tokens are emitted after release.

Optional Feature:
- Macro SEGRW_RMW_SATURATE_EN.
- Defined: the add saturates at 2^DATA_W-1 (e.g. 0xF0+0x20 → 0xFF).
- Undefined: wrap-around (0xF0+0x20 → 0x10).
- Handshake timing is identical in both builds.

Decomposition:
- Shared package segrw_pkg:
  - state encoding constants IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESULT, EOS_ISSUE;
  - default ADDR_W/DATA_W;
  - read/write encoding constants (RD=0, WR=1).
- One sub-module, segrw_rmw_init_dp: address/increment/read-data registers and the adder (wrap or saturate). The top holds the FSM and taken flags.

Test Plan:
- Segment word[3]=0x05, request (addr=3, inc=0x02), no back-pressure → read issued t+1, write (addr=3, dataW=0x07) at t+3, res_d=0x07 at t+4, word[3]=0x07.
- Stagger back-pressure: addr_b held 1 for 3 cycles, write_b free → write token transfers once, addr held stable; after addr transfers, RD_WAIT entered; no duplicate tokens.
- word=0xF0, inc=0x20 → res_d=0x10 without the macro, 0xFF with SEGRW_RMW_SATURATE_EN.
- EOS request → one _e token on each of addr/write/dataW/res, then IDLE with req_b=0; a following data request completes normally.
- dataR returned with dataR_e=1 during RD_WAIT → err=1, no write, no res token, IDLE.
- reset=0 asserted during WR_ISSUE → all _v=0 immediately; after release no write/result emitted, req_b=0.
